// File: rtl/serial_nibble_receiver_if.sv
// ============================================================================
// Module      : serial_nibble_receiver_if
// Description : Serial line, bit strobe, word handshake and status signals
//               shared by a serial_nibble_receiver and the logic around it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_nibble_receiver_if #(
  parameter int WIDTH = 4
);
  logic             SerialIn;  // serial line, idle high
  logic             Enable;    // bit strobe
  logic             Dir;       // 0: first data bit -> Q[0], 1: -> Q[WIDTH-1]
  logic             Ready;     // consumer accepts the word held in Q
  logic [0:WIDTH-1] Q;         // received word
  logic             Valid;     // Q holds an unconsumed word
  logic             Busy;      // frame in progress (data or stop bit)
  logic             FrameErr;  // one-cycle pulse on a bad stop bit
  logic             Overrun;   // sticky: a completed word was dropped

  // Side that drives the line and consumes words.
  modport master (
    output SerialIn, Enable, Dir, Ready,
    input  Q, Valid, Busy, FrameErr, Overrun
  );

  // Receiver side.
  modport slave (
    input  SerialIn, Enable, Dir, Ready,
    output Q, Valid, Busy, FrameErr, Overrun
  );
endinterface

`default_nettype wire

// File: rtl/serial_nibble_receiver.sv
// ============================================================================
// Module      : serial_nibble_receiver
// Description : Strobed serial receiver. A low start bit is followed by WIDTH
//               data bits and a high stop bit; completed words are offered on
//               a Valid/Ready handshake with overrun and framing-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_nibble_receiver #(
  parameter int WIDTH = 4
) (
  input  wire logic               Clock,
  input  wire logic               Resetn,
  serial_nibble_receiver_if.slave bus
);

  // Counter holds 0..WIDTH so it never wraps after the last data bit.
  localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dir;
  logic [0:WIDTH-1]   r_shreg;
  logic [0:WIDTH-1]   r_q;
  logic               r_valid;
  logic               r_frame_err;
  logic               r_overrun;
  logic               w_word_done;
  logic               w_stop_bad;
  logic               w_accept;
  logic [c_CNT_W-1:0] w_bit_idx;

  // The consumer handshake is evaluated on every edge, independent of Enable.
  assign w_accept  = r_valid & bus.Ready;
  // Slot for the current data bit, mirrored when Dir was high at the start bit.
  assign w_bit_idx = r_dir ? (c_LAST_BIT - r_cnt) : r_cnt;

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; every frame transition waits for a bit strobe.
  always_comb begin
    w_next_state = r_state;
    w_word_done  = 1'b0;
    w_stop_bad   = 1'b0;
    if (bus.Enable) begin
      unique case (r_state)
        IDLE: begin
          if (!bus.SerialIn) w_next_state = DATA;
        end
        DATA: begin
          if (r_cnt == c_LAST_BIT) w_next_state = STOP;
        end
        STOP: begin
          if (bus.SerialIn) begin
            w_word_done  = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_next_state = BREAK;
          end
        end
        BREAK: begin
          // Line must return high before a new start bit can count.
          if (bus.SerialIn) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Bit counter, latched direction and shift register; frozen between strobes.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_shreg <= '0;
    end else if (bus.Enable) begin
      if (r_state == IDLE && !bus.SerialIn) begin
        r_cnt <= '0;
        r_dir <= bus.Dir;
      end else if (r_state == DATA) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (w_bit_idx == c_CNT_W'(i)) r_shreg[i] <= bus.SerialIn;
        end
        r_cnt <= r_cnt + c_ONE;
      end
    end
  end

  // Output word, handshake and status flags.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_q         <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      if (w_word_done) begin
        if (!r_valid || bus.Ready) begin
          // Slot is free, or the old word leaves on this same edge.
          r_q     <= r_shreg;
          r_valid <= 1'b1;
          if (w_accept) r_overrun <= 1'b0;
        end else begin
          // Held word is still unconsumed: keep it, drop the new one.
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.Q        = r_q;
  assign bus.Valid    = r_valid;
  assign bus.Busy     = (r_state == DATA) || (r_state == STOP);
  assign bus.FrameErr = r_frame_err;
  assign bus.Overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_receiver.sv
// ============================================================================
// Module      : tb_serial_nibble_receiver
// Description : Directed self-checking bench for serial_nibble_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_nibble_receiver;

  logic Clock  = 1'b0;
  logic Resetn = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;

  serial_nibble_receiver_if #(.WIDTH(4)) bus ();

  serial_nibble_receiver #(.WIDTH(4)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  // Advance one edge; outputs are then read 1 time unit after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One strobed bit; line returns high with strobe off afterwards.
  task automatic strobe(input logic b);
    bus.SerialIn = b;
    bus.Enable   = 1'b1;
    tick();
    bus.Enable   = 1'b0;
    bus.SerialIn = 1'b1;
  endtask

  // Start bit with the given Dir, Dir flipped during data to prove it is latched.
  task automatic send_frame(input logic dir, input logic [0:3] bits, input logic stop);
    bus.Dir = dir;
    strobe(1'b0);
    bus.Dir = ~dir;
    for (int i = 0; i < 4; i++) strobe(bits[i]);
    strobe(stop);
  endtask

  task automatic test_reset();
    #1 Resetn = 1'b0;
    #2;
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Busy, bus.FrameErr, bus.Overrun} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {bus.Q, bus.Valid, bus.Busy, bus.FrameErr, bus.Overrun});
    end
    tick();
    tick();
    #2 Resetn = 1'b1;
    strobe(1'b1);
    strobe(1'b1);
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Busy, bus.FrameErr, bus.Overrun} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_idle_after_release: got %b expected 00000000",
               {bus.Q, bus.Valid, bus.Busy, bus.FrameErr, bus.Overrun});
    end
  endtask

  task automatic test_basic();
    logic [0:3] d;
    d = 4'b1011;
    bus.Ready = 1'b0;
    bus.Dir   = 1'b0;
    strobe(1'b0);
    n_vec++;
    if (bus.Busy !== 1'b1) begin
      n_err++; $display("FAIL basic_busy_data: got %b expected 1", bus.Busy);
    end
    for (int i = 0; i < 4; i++) strobe(d[i]);
    n_vec++;
    if ({bus.Busy, bus.Valid} !== 2'b10) begin
      n_err++; $display("FAIL basic_stop_wait: busy,valid got %b expected 10", {bus.Busy, bus.Valid});
    end
    strobe(1'b1);
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Busy} !== 6'b1011_1_0) begin
      n_err++; $display("FAIL basic_word: q,valid,busy got %b expected 101110", {bus.Q, bus.Valid, bus.Busy});
    end
    tick();
    n_vec++;
    if ({bus.Q, bus.Valid} !== 5'b1011_1) begin
      n_err++; $display("FAIL basic_hold: q,valid got %b expected 10111", {bus.Q, bus.Valid});
    end
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
  endtask

  task automatic test_dir();
    send_frame(1'b1, 4'b1011, 1'b1);
    n_vec++;
    if ({bus.Q, bus.Valid} !== 5'b1101_1) begin
      n_err++; $display("FAIL dir_word: q,valid got %b expected 11011", {bus.Q, bus.Valid});
    end
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
    n_vec++;
    if ({bus.Q, bus.Valid} !== 5'b1101_0) begin
      n_err++; $display("FAIL dir_accept: q,valid got %b expected 11010", {bus.Q, bus.Valid});
    end
    tick();
    n_vec++;
    if (bus.Valid !== 1'b0) begin
      n_err++; $display("FAIL dir_valid_stays_low: got %b expected 0", bus.Valid);
    end
  endtask

  task automatic test_frame_err();
    send_frame(1'b0, 4'b1111, 1'b0);
    n_vec++;
    if ({bus.FrameErr, bus.Valid, bus.Busy} !== 3'b100) begin
      n_err++; $display("FAIL ferr_pulse: ferr,valid,busy got %b expected 100", {bus.FrameErr, bus.Valid, bus.Busy});
    end
    strobe(1'b0);
    n_vec++;
    if ({bus.FrameErr, bus.Busy} !== 2'b00) begin
      n_err++; $display("FAIL ferr_one_cycle_break: ferr,busy got %b expected 00", {bus.FrameErr, bus.Busy});
    end
    strobe(1'b0);
    n_vec++;
    if ({bus.Busy, bus.Valid} !== 2'b00) begin
      n_err++; $display("FAIL ferr_no_start_in_break: busy,valid got %b expected 00", {bus.Busy, bus.Valid});
    end
    strobe(1'b1);
    bus.Dir = 1'b0;
    strobe(1'b0);
    n_vec++;
    if (bus.Busy !== 1'b1) begin
      n_err++; $display("FAIL ferr_start_after_idle: busy got %b expected 1", bus.Busy);
    end
    strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b1);
    strobe(1'b1);
    n_vec++;
    if ({bus.Q, bus.Valid, bus.FrameErr} !== 6'b0101_1_0) begin
      n_err++; $display("FAIL ferr_recovery_word: q,valid,ferr got %b expected 010110", {bus.Q, bus.Valid, bus.FrameErr});
    end
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
  endtask

  task automatic test_overrun();
    send_frame(1'b0, 4'b1010, 1'b1);
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Overrun} !== 6'b1010_1_0) begin
      n_err++; $display("FAIL ovr_first: q,valid,ovr got %b expected 101010", {bus.Q, bus.Valid, bus.Overrun});
    end
    send_frame(1'b0, 4'b0110, 1'b1);
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Overrun} !== 6'b1010_1_1) begin
      n_err++; $display("FAIL ovr_dropped: q,valid,ovr got %b expected 101011", {bus.Q, bus.Valid, bus.Overrun});
    end
    bus.Dir = 1'b0;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    bus.Ready = 1'b1;
    strobe(1'b1);
    bus.Ready = 1'b0;
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Overrun} !== 6'b1111_1_0) begin
      n_err++; $display("FAIL ovr_accept_same_edge: q,valid,ovr got %b expected 111110", {bus.Q, bus.Valid, bus.Overrun});
    end
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
    n_vec++;
    if (bus.Valid !== 1'b0) begin
      n_err++; $display("FAIL ovr_final_accept: valid got %b expected 0", bus.Valid);
    end
  endtask

  // Strobe once, then two idle cycles with the line inverted to show it is ignored.
  task automatic gap_bit(input logic b);
    strobe(b);
    bus.SerialIn = ~b;
    tick();
    tick();
    bus.SerialIn = 1'b1;
  endtask

  task automatic test_enable_gaps();
    logic [0:3] d;
    d = 4'b1011;
    bus.Dir = 1'b0;
    gap_bit(1'b0);
    n_vec++;
    if (bus.Busy !== 1'b1) begin
      n_err++; $display("FAIL gap_busy_after_start: got %b expected 1", bus.Busy);
    end
    for (int i = 0; i < 4; i++) gap_bit(d[i]);
    n_vec++;
    if ({bus.Busy, bus.Valid} !== 2'b10) begin
      n_err++; $display("FAIL gap_busy_before_stop: busy,valid got %b expected 10", {bus.Busy, bus.Valid});
    end
    strobe(1'b1);
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Busy} !== 6'b1011_1_0) begin
      n_err++; $display("FAIL gap_word: q,valid,busy got %b expected 101110", {bus.Q, bus.Valid, bus.Busy});
    end
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_frame(1'b0, 4'b0110, 1'b1);
    send_frame(1'b0, 4'b1001, 1'b1);
    bus.Dir = 1'b0;
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Busy, bus.Overrun} !== 7'b0110_1_1_1) begin
      n_err++; $display("FAIL rstmid_before: q,valid,busy,ovr got %b expected 0110111", {bus.Q, bus.Valid, bus.Busy, bus.Overrun});
    end
    #2 Resetn = 1'b0;
    #1;
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Busy, bus.FrameErr, bus.Overrun} !== 8'h00) begin
      n_err++; $display("FAIL rstmid_async_clear: got %b expected 00000000",
                        {bus.Q, bus.Valid, bus.Busy, bus.FrameErr, bus.Overrun});
    end
    #2 Resetn = 1'b1;
    strobe(1'b1);
    strobe(1'b1);
    n_vec++;
    if ({bus.Busy, bus.Valid} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_idle: busy,valid got %b expected 00", {bus.Busy, bus.Valid});
    end
    send_frame(1'b0, 4'b0011, 1'b1);
    n_vec++;
    if ({bus.Q, bus.Valid, bus.Overrun} !== 6'b0011_1_0) begin
      n_err++; $display("FAIL rstmid_fresh_word: q,valid,ovr got %b expected 001110", {bus.Q, bus.Valid, bus.Overrun});
    end
  endtask

  initial begin
    bus.SerialIn = 1'b1;
    bus.Enable   = 1'b0;
    bus.Dir      = 1'b0;
    bus.Ready    = 1'b0;
    test_reset();
    test_basic();
    test_dir();
    test_frame_err();
    test_overrun();
    test_enable_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/serial_nibble_receiver.md
SERIAL_NIBBLE_RECEIVER -- requirements
Module: serial_nibble_receiver

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 4, the number of data bits per frame and the width of Q.
REQ-002 The module SHALL have port Clock, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port Resetn, input, 1 bit, an asynchronous active-low reset.
REQ-004 The module SHALL have port SerialIn, input, 1 bit, the serial line, idle high.
REQ-005 The module SHALL have port Enable, input, 1 bit, the bit strobe; SerialIn is sampled only on edges where Enable=1.
REQ-006 The module SHALL have port Dir, input, 1 bit: 0 = first data bit lands in Q[0]; 1 = first data bit lands in Q[WIDTH-1]; Dir is sampled at the start bit and held for the frame.
REQ-007 The module SHALL have port Ready, input, 1 bit, the consumer accept signal.
REQ-008 The module SHALL have port Q, output, bits [0:WIDTH-1], the received word, registered.
REQ-009 The module SHALL have port Valid, output, 1 bit, asserted while Q holds an unconsumed word.
REQ-010 The module SHALL have port Busy, output, 1 bit, asserted in states DATA and STOP.
REQ-011 The module SHALL have port FrameErr, output, 1 bit, a one-cycle pulse on a bad stop bit.
REQ-012 The module SHALL have port Overrun, output, 1 bit, sticky; set when a word is lost.

Function
REQ-013 The FSM SHALL have states IDLE, DATA, STOP and BREAK; all transitions occur only on edges with Enable=1, except the Valid/Ready handshake, which is evaluated every edge.
REQ-014 In IDLE, a sampled SerialIn=0 (start bit) SHALL clear the bit counter, latch Dir and move to DATA.
REQ-015 In DATA, each sampled bit SHALL be written into the internal shift register at the position given by the counter and the latched Dir, and the counter SHALL increment.
REQ-016 After WIDTH data bits, the FSM SHALL move to STOP; the counter SHALL NOT wrap or overflow.
REQ-017 In STOP with sampled SerialIn=1, the word SHALL complete and the FSM SHALL return to IDLE.
REQ-018 In STOP with sampled SerialIn=0, FrameErr SHALL pulse for exactly one cycle, the word SHALL be discarded, and the FSM SHALL go to BREAK.
REQ-019 BREAK SHALL remain until a sampled SerialIn=1, then go to IDLE; no start bit is recognised in BREAK.
REQ-020 A word is accepted when Valid=1 and Ready=1 on an edge; Valid SHALL then clear on that edge.
REQ-021 On word completion with Valid=0, or with Valid=1 and Ready=1 on the same edge, Q SHALL load the new word and Valid SHALL be 1 on the next cycle.
REQ-022 On word completion with Valid=1 and Ready=0, the new word SHALL be dropped, Q SHALL be unchanged, and Overrun SHALL be set.
REQ-023 Overrun SHALL clear on the next accepted word.
REQ-024 Q SHALL remain stable while Valid=1 until accepted.
REQ-025 Latency SHALL be one cycle from the stop-bit sample edge to Valid=1.
REQ-026 Edges with Enable=0 SHALL leave the FSM, counter and shift register unchanged.

Reset
REQ-027 Resetn=0 SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, shift register 0, Q=0, Valid=0, Busy=0, FrameErr=0 and Overrun=0.
REQ-028 Reset asserted mid-frame SHALL abandon the partial word; after release, the receiver SHALL wait in IDLE for a fresh start bit.

Verification
REQ-029 Dir=0, Enable=1 every cycle, frame 0,1,0,1,1,1 (start, data 1,0,1,1, stop) with Ready=0 -> Q=1011 (Q[0]=1), Valid=1 one cycle after the stop sample, Busy low.
REQ-030 Same frame with Dir=1 -> Q=1101; Ready=1 for one cycle -> Valid=0 on the next edge, Q holds 1101.
REQ-031 Frame with stop bit 0 -> FrameErr high for exactly one cycle, Valid stays 0, no start bit recognised until SerialIn has been sampled at 1.
REQ-032 Two frames 1010 then 0110 with Ready=0 throughout -> Q=1010, Overrun=1; Ready=1 on the edge the third word 1111 completes -> Q=1111, Valid stays 1, Overrun clears.
REQ-033 Enable pulsed every 3rd cycle -> same results as REQ-029, with Busy spanning the data and stop strobes only.
REQ-034 Resetn pulled low after 2 data bits -> all outputs 0 asynchronously; a following full frame 0011 is received correctly.
